// File: rtl/mxv_sequencer_pkg.sv
// Shared definitions for the matrix-vector sequencer: FSM state encoding
// and default datapath geometry.
package mxv_sequencer_pkg;

    localparam int MXV_ROWS    = 4;
    localparam int MXV_MAC_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        EMIT,
        DONE
    } MXV_SEQ_STATE;

endpackage

// File: rtl/mxv_sequencer_pop_delay_line.sv
// Single-bit shift register delaying a pop/enable strobe by DEPTH cycles,
// with asynchronous reset and a synchronous clear for aborts.
module pop_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    if (DEPTH == 1) begin : g_one
        assign sr_d = d_i;
    end else begin : g_multi
        assign sr_d = {sr_q[DEPTH-2:0], d_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (clear_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mxv_sequencer.sv
// Sequencer for one N x N matrix-vector multiply: clear, feed, drain, emit.
// Define MXV_SEQ_PERF_EN to build the start-to-done cycle counter on perf_cycles.
module mxv_sequencer
    import mxv_sequencer_pkg::*;
#(
    parameter int ROWS    = MXV_ROWS,
    parameter int NW      = 4,
    parameter int MAC_LAT = MXV_MAC_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NW-1:0]   n,
    input  logic            sync_clear,
    input  logic            out_ready,
    output logic            pop_vec,
    output logic [ROWS-1:0] row_pop,
    output logic            acc_clear,
    output logic [ROWS-1:0] acc_en,
    output logic            result_push,
    output logic [NW-1:0]   result_sel,
    output logic            busy,
    output logic            done,
    output logic [15:0]     perf_cycles
);

    localparam int CW = NW + 2;

    MXV_SEQ_STATE    state_q, state_d;
    logic [NW-1:0]   n_l_q, n_l_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   n_ext, n_clamp, feed_last, drain_last;
    logic [ROWS-1:0] stagger;

    assign n_ext      = CW'(n_l_q);
    assign n_clamp    = (CW'(n) > CW'(ROWS)) ? CW'(ROWS) : CW'(n);
    assign feed_last  = n_ext - CW'(1);
    // DRAIN lasts (n_l-1)+MAC_LAT cycles, so its last count is n_l+MAC_LAT-2
    assign drain_last = n_ext + CW'(MAC_LAT) - CW'(2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_l_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_l_q   <= n_l_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_l_d   = n_l_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_l_d   = n_clamp[NW-1:0];
                    cnt_d   = '0;
                    state_d = (n_clamp == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (cnt_q == feed_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == drain_last) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (cnt_q == feed_last) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (sync_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        pop_vec     = (state_q == FEED);
        acc_clear   = (state_q == CLEAR);
        result_push = (state_q == EMIT) && out_ready;
        result_sel  = (state_q == EMIT) ? cnt_q[NW-1:0] : '0;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
    end

    // Row k pops k cycles after the vector pop; rows beyond n_l are masked
    assign stagger[0] = pop_vec;
    assign row_pop[0] = pop_vec;

    for (genvar gi = 1; gi < ROWS; gi++) begin : g_stagger
        pop_delay_line #(.DEPTH(1)) u_stagger (
            .clk     (clk),
            .reset   (reset),
            .clear_i (sync_clear),
            .d_i     (stagger[gi-1]),
            .q_o     (stagger[gi])
        );
        assign row_pop[gi] = stagger[gi] & (CW'(gi) < n_ext);
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_acc
        pop_delay_line #(.DEPTH(MAC_LAT)) u_acc (
            .clk     (clk),
            .reset   (reset),
            .clear_i (sync_clear),
            .d_i     (row_pop[gi]),
            .q_o     (acc_en[gi])
        );
    end

`ifdef MXV_SEQ_PERF_EN
    logic [15:0] perf_cnt_q, perf_cnt_d;
    logic [15:0] perf_q, perf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_q     <= perf_d;
        end
    end

    // Count includes the start-accept cycle and the DONE cycle itself
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        perf_d     = perf_q;
        if (state_q == IDLE) begin
            if (start) perf_cnt_d = 16'd1;
        end else if (perf_cnt_q != 16'hFFFF) begin
            perf_cnt_d = perf_cnt_q + 16'd1;
        end
        if ((state_q == DONE) && !sync_clear) begin
            perf_d = (perf_cnt_q == 16'hFFFF) ? perf_cnt_q : perf_cnt_q + 16'd1;
        end
        if (sync_clear) perf_cnt_d = '0;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mxv_sequencer.sv
// Directed testbench for mxv_sequencer (ROWS=4, NW=4, MAC_LAT=2).
module tb_mxv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, sync_clear, out_ready;
    logic [3:0]  n;
    logic        pop_vec, acc_clear, result_push, busy, done;
    logic [3:0]  row_pop, acc_en, result_sel;
    logic [15:0] perf_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic       r_pv[64], r_ac[64], r_push[64], r_done[64], r_busy[64];
    logic [3:0] r_rp[64], r_ae[64], r_sel[64];

    always #5 clk = ~clk;

    mxv_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n           (n),
        .sync_clear  (sync_clear),
        .out_ready   (out_ready),
        .pop_vec     (pop_vec),
        .row_pop     (row_pop),
        .acc_clear   (acc_clear),
        .acc_en      (acc_en),
        .result_push (result_push),
        .result_sel  (result_sel),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    function automatic logic rng(input int c, input int a, input int b);
        return (c >= a) && (c <= b);
    endfunction

    // Cycle 0 drives start; cycle c is sampled after c clock edges.
    task automatic run(input int nval, input int ncyc, input logic [63:0] rdy_mask,
                       input int clr_at, input int start2_at, input int rst_at);
        for (int c = 0; c < ncyc; c++) begin
            start      = (c == 0) || (c == start2_at);
            n          = nval[3:0];
            out_ready  = rdy_mask[c];
            sync_clear = (c == clr_at);
            reset      = (c == rst_at);
            #1;
            r_pv[c] = pop_vec;   r_ac[c] = acc_clear;  r_push[c] = result_push;
            r_done[c] = done;    r_busy[c] = busy;     r_rp[c] = row_pop;
            r_ae[c] = acc_en;    r_sel[c] = result_sel;
            @(posedge clk);
            #1;
        end
        start = 0; sync_clear = 0; reset = 0; out_ready = 0;
    endtask

    task automatic test_reset;
        reset = 1; start = 0; sync_clear = 0; out_ready = 0; n = 0;
        #1;
        n_checks++;
        if ({pop_vec, row_pop, acc_clear, acc_en, result_push, result_sel, busy, done, perf_cycles} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got pv=%b rp=%b ac=%b ae=%b push=%b sel=%0d busy=%b done=%b perf=%0d, want all 0",
                     pop_vec, row_pop, acc_clear, acc_en, result_push, result_sel, busy, done, perf_cycles);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        $display("reset: outputs checked idle");
    endtask

    task automatic test_n3;
        logic [17:0] got, exp;
        run(3, 14, '1, -1, -1, -1);
        for (int c = 0; c < 14; c++) begin
            got = {r_ac[c], r_pv[c], r_rp[c], r_ae[c], r_push[c], r_sel[c], r_done[c], r_busy[c]};
            exp = {rng(c,1,1), rng(c,2,4),
                   1'b0, rng(c,4,6), rng(c,3,5), rng(c,2,4),
                   1'b0, rng(c,6,8), rng(c,5,7), rng(c,4,6),
                   rng(c,9,11), (rng(c,9,11) ? 4'(c-9) : 4'd0),
                   rng(c,12,12), rng(c,1,12)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL n3_cycle%0d: got %b, want %b (ac,pv,rp,ae,push,sel,done,busy)", c, got, exp);
            end
        end
        $display("n3: 14 cycles compared against hand timeline");
    endtask

    task automatic test_n0;
        logic [4:0] got, exp;
        run(0, 4, '1, -1, -1, -1);
        for (int c = 0; c < 4; c++) begin
            got = {r_ac[c], r_pv[c], r_push[c], r_done[c], r_busy[c]};
            exp = {3'b000, rng(c,1,1), rng(c,1,1)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL n0_cycle%0d: got %b, want %b (ac,pv,push,done,busy)", c, got, exp);
            end
        end
        $display("n0: zero-size start checked");
    endtask

    task automatic test_clamp;
        int pops = 0, pushes = 0, rp3 = 0, dones = 0;
        run(9, 20, '1, -1, -1, -1);
        for (int c = 0; c < 20; c++) begin
            pops += int'(r_pv[c]); pushes += int'(r_push[c]);
            rp3 += int'(r_rp[c][3]); dones += int'(r_done[c]);
        end
        n_checks++;
        if (pops != 4 || pushes != 4 || rp3 != 4) begin
            n_fail++;
            $display("FAIL clamp_counts: got pops=%0d pushes=%0d rp3=%0d, want 4 4 4", pops, pushes, rp3);
        end
        n_checks++;
        if (dones != 1 || r_done[15] !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_done: got dones=%0d done@15=%b, want 1 and 1", dones, r_done[15]);
        end
        $display("clamp: n=9 run with %0d pops %0d pushes", pops, pushes);
    endtask

    task automatic test_out_ready_stall;
        logic [63:0] mask;
        int k = 0, dones = 0;
        int exp_cyc[4] = '{11, 14, 15, 17};
        mask = ~((64'd1 << 12) | (64'd1 << 13) | (64'd1 << 16));
        run(4, 22, mask, -1, -1, -1);
        for (int c = 0; c < 22; c++) begin
            dones += int'(r_done[c]);
            if (r_push[c]) begin
                n_checks++;
                if (k > 3 || c != exp_cyc[k] || r_sel[c] !== 4'(k)) begin
                    n_fail++;
                    $display("FAIL stall_push%0d: got cycle=%0d sel=%0d, want cycle=%0d sel=%0d",
                             k, c, r_sel[c], (k > 3) ? -1 : exp_cyc[k], k);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 4 || dones != 1 || r_done[18] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_totals: got pushes=%0d dones=%0d done@18=%b, want 4 1 1", k, dones, r_done[18]);
        end
        $display("stall: out_ready 1,0,0,1,1,0,1 gave %0d pushes", k);
    endtask

    task automatic test_start_in_drain;
        int pops = 0, pushes = 0, dones = 0;
        run(3, 16, '1, -1, 6, -1);
        for (int c = 0; c < 16; c++) begin
            pops += int'(r_pv[c]); pushes += int'(r_push[c]); dones += int'(r_done[c]);
        end
        n_checks++;
        if (pops != 3 || pushes != 3 || dones != 1 || r_done[12] !== 1'b1 || r_busy[13] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_drain: got pops=%0d pushes=%0d dones=%0d done@12=%b busy@13=%b, want 3 3 1 1 0",
                     pops, pushes, dones, r_done[12], r_busy[13]);
        end
        $display("start_in_drain: second start ignored");
    endtask

    task automatic test_sync_clear;
        logic [63:0] mask;
        logic [15:0] perf_before;
        int pushes = 0, dones = 0;
        perf_before = perf_cycles;
        mask = ~(64'd1 << 11);
        run(3, 15, mask, 11, -1, -1);
        for (int c = 0; c < 15; c++) begin
            pushes += int'(r_push[c]); dones += int'(r_done[c]);
        end
        n_checks++;
        if (pushes != 2 || dones != 0) begin
            n_fail++;
            $display("FAIL sync_clear_counts: got pushes=%0d dones=%0d, want 2 0", pushes, dones);
        end
        n_checks++;
        if ({r_busy[12], r_pv[12], r_rp[12], r_ae[12], r_sel[12]} !== '0) begin
            n_fail++;
            $display("FAIL sync_clear_idle: got busy=%b pv=%b rp=%b ae=%b sel=%0d, want all 0",
                     r_busy[12], r_pv[12], r_rp[12], r_ae[12], r_sel[12]);
        end
        n_checks++;
        if (perf_cycles !== perf_before) begin
            n_fail++;
            $display("FAIL sync_clear_perf: got %0d, want %0d", perf_cycles, perf_before);
        end
        $display("sync_clear: abort in EMIT after %0d pushes", pushes);
    endtask

    task automatic test_reset_mid;
        int pops = 0, pushes = 0, rp3 = 0;
        run(4, 8, '1, -1, -1, 3);
        n_checks++;
        if ({r_pv[3], r_rp[3], r_ac[3], r_ae[3], r_push[3], r_busy[3], r_done[3]} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_zero: got pv=%b rp=%b ae=%b busy=%b, want all 0",
                     r_pv[3], r_rp[3], r_ae[3], r_busy[3]);
        end
        n_checks++;
        if (r_busy[4] !== 1'b0 || r_pv[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got busy=%b pv=%b, want 0 0", r_busy[4], r_pv[4]);
        end
        run(4, 17, '1, -1, -1, -1);
        for (int c = 0; c < 17; c++) begin
            pops += int'(r_pv[c]); pushes += int'(r_push[c]); rp3 += int'(r_rp[c][3]);
        end
        n_checks++;
        if (pops != 4 || pushes != 4 || rp3 != 4 || r_done[15] !== 1'b1 || r_ac[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: got pops=%0d pushes=%0d rp3=%0d done@15=%b ac@1=%b, want 4 4 4 1 1",
                     pops, pushes, rp3, r_done[15], r_ac[1]);
        end
        $display("reset_mid: abort then clean n=4 rerun");
    endtask

    task automatic test_perf;
        logic [15:0] want;
        run(2, 12, '1, -1, -1, -1);
`ifdef MXV_SEQ_PERF_EN
        want = 16'd10;
`else
        want = 16'd0;
`endif
        n_checks++;
        if (perf_cycles !== want || r_done[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL perf_cycles: got %0d done@9=%b, want %0d and 1", perf_cycles, r_done[9], want);
        end
        $display("perf: n=2 perf_cycles=%0d", perf_cycles);
    endtask

    initial begin
        test_reset;
        test_n3;
        test_n0;
        test_clamp;
        test_out_ready_stall;
        test_start_in_drain;
        test_perf;
        test_sync_clear;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
